// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//
// Purpose:
//   Execute stage of a simple in-order pipeline. It accepts one operation per
//   cycle through a valid/ready handshake and evaluates it in the ALU. MUL runs
//   as a 32-iteration shift-add sequence and blocks new accepts while it runs.
//   Each result goes into a single-entry output register together with the
//   flags, the branch decision, the branch target and the control passthroughs.
//
// Ports:
//   clock            main clock, rising edge
//   resetN           synchronous active-low reset
//   inValid/inReady  upstream handshake
//   aluOp            operation select
//   readData1/2      operands A / B
//   pcOffsetFilled   sign-extended branch offset in words
//   pc               current instruction address
//   branchFlag       conditional branch (taken when result is zero)
//   uncondBranchFlag unconditional branch
//   regWriteIn, memReadIn, memWriteIn, writeRegIn   control passthroughs
//   outValid/outReady downstream handshake
//   aluResult, nzcv, branchTaken, branchTarget      registered results
//   regWriteOut, memReadOut, memWriteOut, writeRegOut registered passthroughs
// -----------------------------------------------------------------------------
module execute_stage (
    input  logic        clock,
    input  logic        resetN,
    input  logic        inValid,
    output logic        inReady,
    input  logic [3:0]  aluOp,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] pcOffsetFilled,
    input  logic [31:0] pc,
    input  logic        branchFlag,
    input  logic        uncondBranchFlag,
    input  logic        regWriteIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic [4:0]  writeRegIn,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] aluResult,
    output logic [3:0]  nzcv,
    output logic        branchTaken,
    output logic [31:0] branchTarget,
    output logic        regWriteOut,
    output logic        memReadOut,
    output logic        memWriteOut,
    output logic [4:0]  writeRegOut
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_LSL  = 4'b1000;
    localparam logic [3:0] OP_LSR  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_EOR  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    // Single-cycle ALU: returns {nzcv, result}. MUL is handled by the
    // sequential multiplier, so it falls into the zero-result default here.
    function automatic logic [35:0] alu_eval(
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] wide;
        logic [31:0] res;
        logic        c;
        logic        v;
        wide = 33'd0;
        res  = 32'd0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            OP_AND:  res = a & b;
            OP_ORR:  res = a | b;
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[31:0];
                c    = wide[32];
                v    = (a[31] == b[31]) && (res[31] != a[31]);
            end
            OP_SUB: begin
                res = a - b;
                // Carry means "no borrow", i.e. A >= B unsigned.
                c   = (a >= b);
                v   = (a[31] != b[31]) && (res[31] != a[31]);
            end
            OP_PASS: res = b;
            OP_LSL:  res = a << b[4:0];
            OP_LSR:  res = a >> b[4:0];
            OP_EOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            default: res = 32'd0;
        endcase
        return {res[31], (res == 32'd0), c, v, res};
    endfunction

    // Branch decision shared by the single-cycle and multiply paths.
    function automatic logic branch_eval(
        input logic        uncond,
        input logic        cond,
        input logic [31:0] res
    );
        return uncond || (cond && (res == 32'd0));
    endfunction

    state_e      state_q, state_d;

    // Multiplier working registers and operation context held during MUL.
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hold_target_q, hold_target_d;
    logic        hold_br_q, hold_br_d;
    logic        hold_ubr_q, hold_ubr_d;
    logic        hold_rw_q, hold_rw_d;
    logic        hold_mr_q, hold_mr_d;
    logic        hold_mw_q, hold_mw_d;
    logic [4:0]  hold_wr_q, hold_wr_d;

    // Output register.
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  nzcv_q, nzcv_d;
    logic        taken_q, taken_d;
    logic [31:0] target_q, target_d;
    logic        rw_q, rw_d;
    logic        mr_q, mr_d;
    logic        mw_q, mw_d;
    logic [4:0]  wr_q, wr_d;

    logic        in_ready_s;
    logic        accept_s;
    logic [35:0] alu_out_s;
    logic [31:0] target_s;
    logic [31:0] acc_step_s;

    // Handshake: accept only when idle and the output slot is free or draining.
    always_comb begin
        in_ready_s = resetN && (state_q == ST_IDLE) && (!out_valid_q || outReady);
        accept_s   = inValid && in_ready_s;
    end

    // Datapath helpers: single-cycle ALU, branch target, one shift-add step.
    always_comb begin
        alu_out_s  = alu_eval(aluOp, readData1, readData2);
        target_s   = pc + (pcOffsetFilled << 2);
        acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // Next-state logic for the FSM, multiplier and output register.
    always_comb begin
        state_d       = state_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        hold_target_d = hold_target_q;
        hold_br_d     = hold_br_q;
        hold_ubr_d    = hold_ubr_q;
        hold_rw_d     = hold_rw_q;
        hold_mr_d     = hold_mr_q;
        hold_mw_d     = hold_mw_q;
        hold_wr_d     = hold_wr_q;
        out_valid_d   = out_valid_q;
        result_d      = result_q;
        nzcv_d        = nzcv_q;
        taken_d       = taken_q;
        target_d      = target_q;
        rw_d          = rw_q;
        mr_d          = mr_q;
        mw_d          = mw_q;
        wr_d          = wr_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s && (aluOp == OP_MUL)) begin
                    state_d       = ST_MUL;
                    mcand_d       = readData1;
                    mplier_d      = readData2;
                    acc_d         = 32'd0;
                    cnt_d         = 5'd0;
                    hold_target_d = target_s;
                    hold_br_d     = branchFlag;
                    hold_ubr_d    = uncondBranchFlag;
                    hold_rw_d     = regWriteIn;
                    hold_mr_d     = memReadIn;
                    hold_mw_d     = memWriteIn;
                    hold_wr_d     = writeRegIn;
                    // Accept implies the slot was empty or is consumed now.
                    out_valid_d   = 1'b0;
                end else if (accept_s) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_out_s[31:0];
                    nzcv_d      = alu_out_s[35:32];
                    taken_d     = branch_eval(uncondBranchFlag, branchFlag, alu_out_s[31:0]);
                    target_d    = target_s;
                    rw_d        = regWriteIn;
                    mr_d        = memReadIn;
                    mw_d        = memWriteIn;
                    wr_d        = writeRegIn;
                end else if (out_valid_q && outReady) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            ST_MUL: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                acc_d    = acc_step_s;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = acc_step_s;
                    nzcv_d      = {acc_step_s[31], (acc_step_s == 32'd0), 1'b0, 1'b0};
                    taken_d     = branch_eval(hold_ubr_q, hold_br_q, acc_step_s);
                    target_d    = hold_target_q;
                    rw_d        = hold_rw_q;
                    mr_d        = hold_mr_q;
                    mw_d        = hold_mw_q;
                    wr_d        = hold_wr_q;
                end else begin
                    state_d = ST_MUL;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            mcand_q       <= 32'd0;
            mplier_q      <= 32'd0;
            acc_q         <= 32'd0;
            cnt_q         <= 5'd0;
            hold_target_q <= 32'd0;
            hold_br_q     <= 1'b0;
            hold_ubr_q    <= 1'b0;
            hold_rw_q     <= 1'b0;
            hold_mr_q     <= 1'b0;
            hold_mw_q     <= 1'b0;
            hold_wr_q     <= 5'd0;
            out_valid_q   <= 1'b0;
            result_q      <= 32'd0;
            nzcv_q        <= 4'd0;
            taken_q       <= 1'b0;
            target_q      <= 32'd0;
            rw_q          <= 1'b0;
            mr_q          <= 1'b0;
            mw_q          <= 1'b0;
            wr_q          <= 5'd0;
        end else begin
            state_q       <= state_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            hold_target_q <= hold_target_d;
            hold_br_q     <= hold_br_d;
            hold_ubr_q    <= hold_ubr_d;
            hold_rw_q     <= hold_rw_d;
            hold_mr_q     <= hold_mr_d;
            hold_mw_q     <= hold_mw_d;
            hold_wr_q     <= hold_wr_d;
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            nzcv_q        <= nzcv_d;
            taken_q       <= taken_d;
            target_q      <= target_d;
            rw_q          <= rw_d;
            mr_q          <= mr_d;
            mw_q          <= mw_d;
            wr_q          <= wr_d;
        end
    end

    assign inReady      = in_ready_s;
    assign outValid     = out_valid_q;
    assign aluResult    = result_q;
    assign nzcv         = nzcv_q;
    assign branchTaken  = taken_q;
    assign branchTarget = target_q;
    assign regWriteOut  = rw_q;
    assign memReadOut   = mr_q;
    assign memWriteOut  = mw_q;
    assign writeRegOut  = wr_q;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//
// Directed self-checking bench for execute_stage. Inputs change on the falling
// edge and outputs are sampled on the falling edge. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_execute_stage;

    logic        clock;
    logic        resetN;
    logic        inValid;
    logic        inReady;
    logic [3:0]  aluOp;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] pcOffsetFilled;
    logic [31:0] pc;
    logic        branchFlag;
    logic        uncondBranchFlag;
    logic        regWriteIn;
    logic        memReadIn;
    logic        memWriteIn;
    logic [4:0]  writeRegIn;
    logic        outValid;
    logic        outReady;
    logic [31:0] aluResult;
    logic [3:0]  nzcv;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        regWriteOut;
    logic        memReadOut;
    logic        memWriteOut;
    logic [4:0]  writeRegOut;

    int checks = 0;
    int errors = 0;

    execute_stage dut (
        .clock            (clock),
        .resetN           (resetN),
        .inValid          (inValid),
        .inReady          (inReady),
        .aluOp            (aluOp),
        .readData1        (readData1),
        .readData2        (readData2),
        .pcOffsetFilled   (pcOffsetFilled),
        .pc               (pc),
        .branchFlag       (branchFlag),
        .uncondBranchFlag (uncondBranchFlag),
        .regWriteIn       (regWriteIn),
        .memReadIn        (memReadIn),
        .memWriteIn       (memWriteIn),
        .writeRegIn       (writeRegIn),
        .outValid         (outValid),
        .outReady         (outReady),
        .aluResult        (aluResult),
        .nzcv             (nzcv),
        .branchTaken      (branchTaken),
        .branchTarget     (branchTarget),
        .regWriteOut      (regWriteOut),
        .memReadOut       (memReadOut),
        .memWriteOut      (memWriteOut),
        .writeRegOut      (writeRegOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic br, input logic ubr,
                          input logic [31:0] pcv, input logic [31:0] off);
        aluOp            = op;
        readData1        = a;
        readData2        = b;
        branchFlag       = br;
        uncondBranchFlag = ubr;
        pc               = pcv;
        pcOffsetFilled   = off;
    endtask

    task automatic step;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        resetN     = 1'b0;
        inValid    = 1'b0;
        outReady   = 1'b1;
        regWriteIn = 1'b0;
        memReadIn  = 1'b0;
        memWriteIn = 1'b0;
        writeRegIn = 5'd0;
        set_op(4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_outValid", {31'd0, outValid}, 32'd0);
        check("rst_result", aluResult, 32'd0);
        check("rst_nzcv", {28'd0, nzcv}, 32'd0);
        check("rst_inReady_low", {31'd0, inReady}, 32'd0);
        resetN = 1'b1;
        #1;
        check("rst_inReady_high", {31'd0, inReady}, 32'd1);

        // ADD overflow into the sign bit
        set_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 32'h0);
        inValid = 1'b1;
        step();
        check("add_valid", {31'd0, outValid}, 32'd1);
        check("add_result", aluResult, 32'h8000_0000);
        check("add_nzcv", {28'd0, nzcv}, 32'h9);
        check("add_taken", {31'd0, branchTaken}, 32'd0);

        // SUB to zero with CBZ, back-to-back with the ADD result
        set_op(4'b0110, 32'd5, 32'd5, 1'b1, 1'b0, 32'h0000_0100, 32'hFFFF_FFFE);
        regWriteIn = 1'b1;
        memReadIn  = 1'b1;
        writeRegIn = 5'd7;
        step();
        check("sub_valid", {31'd0, outValid}, 32'd1);
        check("sub_result", aluResult, 32'h0);
        check("sub_nzcv", {28'd0, nzcv}, 32'h6);
        check("sub_taken", {31'd0, branchTaken}, 32'd1);
        check("sub_target", branchTarget, 32'h0000_00F8);
        check("sub_regwrite", {31'd0, regWriteOut}, 32'd1);
        check("sub_memread", {31'd0, memReadOut}, 32'd1);
        check("sub_memwrite", {31'd0, memWriteOut}, 32'd0);
        check("sub_writereg", {27'd0, writeRegOut}, 32'd7);
        regWriteIn = 1'b0;
        memReadIn  = 1'b0;
        writeRegIn = 5'd0;

        // LSR by 31 with zero fill
        set_op(4'b1001, 32'h8000_0000, 32'd31, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("lsr_result", aluResult, 32'h1);
        check("lsr_nzcv", {28'd0, nzcv}, 32'h0);

        // Undefined opcode gives zero
        set_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("undef_result", aluResult, 32'h0);
        check("undef_nzcv", {28'd0, nzcv}, 32'h4);

        // SUB with borrow, SUB with signed overflow, LSL with B[4:0], EOR, NOR
        set_op(4'b0110, 32'd3, 32'd5, 1'b1, 1'b0, 32'h0, 32'h0);
        step();
        check("sub_borrow_result", aluResult, 32'hFFFF_FFFE);
        check("sub_borrow_nzcv", {28'd0, nzcv}, 32'h8);
        check("sub_borrow_taken", {31'd0, branchTaken}, 32'd0);
        set_op(4'b0110, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("sub_ovf_result", aluResult, 32'h7FFF_FFFF);
        check("sub_ovf_nzcv", {28'd0, nzcv}, 32'h3);
        set_op(4'b1000, 32'd1, 32'h24, 1'b0, 1'b1, 32'h0, 32'h0);
        step();
        check("lsl_result", aluResult, 32'h10);
        check("lsl_uncond_taken", {31'd0, branchTaken}, 32'd1);
        set_op(4'b1011, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("eor_result", aluResult, 32'hF0F0_F0F0);
        check("eor_nzcv", {28'd0, nzcv}, 32'h8);
        set_op(4'b1100, 32'hFFFF_0000, 32'h0000_FF00, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("nor_result", aluResult, 32'h0000_00FF);
        set_op(4'b0111, 32'h1111_1111, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("pass_result", aluResult, 32'hCAFE_0001);
        check("pass_nzcv", {28'd0, nzcv}, 32'h8);

        // MUL: 32 edges after accept, inReady low throughout
        set_op(4'b1010, 32'h0001_0001, 32'h0001_0001, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0004);
        memWriteIn = 1'b1;
        writeRegIn = 5'd3;
        step();
        inValid    = 1'b0;
        memWriteIn = 1'b0;
        writeRegIn = 5'd0;
        check("mul_start_valid", {31'd0, outValid}, 32'd0);
        check("mul_start_ready", {31'd0, inReady}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            step();
            check("mul_busy_ready", {31'd0, inReady}, 32'd0);
            check("mul_busy_valid", {31'd0, outValid}, 32'd0);
        end
        step();
        check("mul_done_valid", {31'd0, outValid}, 32'd1);
        check("mul_result", aluResult, 32'h0002_0001);
        check("mul_nzcv", {28'd0, nzcv}, 32'h0);
        check("mul_taken", {31'd0, branchTaken}, 32'd0);
        check("mul_target", branchTarget, 32'h0000_0050);
        check("mul_memwrite", {31'd0, memWriteOut}, 32'd1);
        check("mul_writereg", {27'd0, writeRegOut}, 32'd3);
        check("mul_done_ready", {31'd0, inReady}, 32'd1);
        step();
        check("consume_clears_valid", {31'd0, outValid}, 32'd0);

        // ORR result stalled by outReady=0 for 5 cycles; a pending AND is ignored
        outReady = 1'b0;
        set_op(4'b0001, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b0, 32'h0, 32'h0);
        inValid = 1'b1;
        step();
        set_op(4'b0000, 32'h0000_FF00, 32'h0000_0F00, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, outValid}, 32'd1);
            check("stall_result", aluResult, 32'h0000_00FF);
            check("stall_nzcv", {28'd0, nzcv}, 32'h0);
            check("stall_ready", {31'd0, inReady}, 32'd0);
            step();
        end
        outReady = 1'b1;
        #1;
        check("release_ready", {31'd0, inReady}, 32'd1);
        step();
        check("b2b_valid", {31'd0, outValid}, 32'd1);
        check("b2b_result", aluResult, 32'h0000_0F00);
        inValid = 1'b0;
        step();
        check("b2b_drain", {31'd0, outValid}, 32'd0);

        // Leave non-zero output data, then abort a MUL with reset at its 10th cycle
        set_op(4'b0010, 32'd1, 32'd2, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0001);
        regWriteIn = 1'b1;
        writeRegIn = 5'd9;
        inValid    = 1'b1;
        step();
        check("pre_abort_target", branchTarget, 32'h0000_0204);
        set_op(4'b1010, 32'd3, 32'd7, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0002);
        step();
        inValid = 1'b0;
        check("abort_mul_ready", {31'd0, inReady}, 32'd0);
        repeat (9) step();
        resetN = 1'b0;
        step();
        check("abort_valid", {31'd0, outValid}, 32'd0);
        check("abort_result", aluResult, 32'h0);
        check("abort_nzcv", {28'd0, nzcv}, 32'h0);
        check("abort_taken", {31'd0, branchTaken}, 32'd0);
        check("abort_target", branchTarget, 32'h0);
        check("abort_regwrite", {31'd0, regWriteOut}, 32'd0);
        check("abort_writereg", {27'd0, writeRegOut}, 32'd0);
        resetN = 1'b1;
        #1;
        check("abort_ready_after_reset", {31'd0, inReady}, 32'd1);
        repeat (35) step();
        check("abort_no_output", {31'd0, outValid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have these ports, in this order:
- clock  input  1  main clock; all state updates on rising edge.
- resetN  input  1  synchronous, active-low reset.
- inValid  input  1  upstream operands valid.
- inReady  output  1  stage can accept an operation this cycle.
- aluOp  input  4  operation select (REQ-008).
- readData1  input  32  operand A.
- readData2  input  32  operand B (register or sign-extended immediate).
- pcOffsetFilled  input  32  sign-extended branch offset, in words.
- pc  input  32  address of the current instruction.
- branchFlag  input  1  conditional branch (CBZ).
- uncondBranchFlag  input  1  unconditional branch.
- regWriteIn, memReadIn, memWriteIn  input  1 each  control passthrough.
- writeRegIn  input  5  destination register passthrough.
- outValid  output  1  result valid.
- outReady  input  1  downstream accepts the result.
- aluResult  output  32  operation result.
- nzcv  output  4  flags {N,Z,C,V}.
- branchTaken  output  1  branch decision.
- branchTarget  output  32  branch target address.
- regWriteOut, memReadOut, memWriteOut  output  1 each  registered passthroughs.
- writeRegOut  output  5  registered passthrough.
REQ-002 SHALL use one clock domain (clock) and one reset (resetN, synchronous, active-low); no other clocks or asynchronous logic.

Function
REQ-003 SHALL have states IDLE and MUL, plus a single-entry output register qualified by outValid.
REQ-004 SHALL drive inReady = resetN && state==IDLE && (!outValid || outReady).
REQ-005 SHALL accept an operation on a rising edge where inValid && inReady, capturing all inputs.
REQ-006 For a non-MUL op accepted at edge E, SHALL load the output register and set outValid at edge E (latency 1 cycle).
REQ-007 For a MUL op accepted at edge E, SHALL enter MUL and run 32 shift-add iterations on edges E+1..E+32; at edge E+32 SHALL load the output register, set outValid and return to IDLE; inReady SHALL be 0 throughout.
REQ-008 aluOp encoding:
- 0000 AND; 0001 ORR; 0010 ADD; 0110 SUB (A-B); 0111 PASS B.
- 1000 LSL A by B[4:0]; 1001 LSR A by B[4:0], zero fill.
- 1010 MUL, low 32 bits of the product; 1011 EOR; 1100 NOR.
- Any other code gives result 0.
REQ-009 All arithmetic SHALL be modulo 2^32.
REQ-010 Flags SHALL be: N=result[31]; Z=(result==0). For ADD: C=carry out of bit 31, V=signed overflow. For SUB: C=1 when there is no borrow (A>=B unsigned), V=signed overflow. All other ops: C=V=0.
REQ-011 SHALL compute branchTaken = uncondBranchFlag || (branchFlag && result==0), registered with the result.
REQ-012 SHALL compute branchTarget = pc + (pcOffsetFilled<<2) mod 2^32, registered with the result.
REQ-013 Passthrough outputs SHALL be registered with the result, so they align with outValid.
REQ-014 While outValid && !outReady, all outputs SHALL hold stable.
REQ-015 At the edge where outValid && outReady with no new accept or MUL completion, SHALL clear outValid.
REQ-016 A simultaneous output consume and new accept SHALL replace the output register, with outValid staying 1 (back-to-back throughput of 1 op per cycle).
REQ-017 inValid while inReady=0 SHALL be ignored; upstream holds its inputs.

Reset
REQ-018 On any edge with resetN=0: state=IDLE, outValid=0, aluResult=0, nzcv=0, branchTaken=0, branchTarget=0, all passthroughs=0.
REQ-019 Reset during MUL SHALL abort the multiply with no output produced; inReady=1 on the first cycle after resetN rises.

Verification
REQ-020 Bench SHALL cover:
- ADD A=0x7FFFFFFF, B=1 -> result 0x80000000, nzcv=1001, outValid one cycle after accept.
- SUB A=5, B=5 with branchFlag=1, pc=0x100, offset=0xFFFFFFFE -> result 0, nzcv=0110, branchTaken=1, branchTarget=0x0F8.
- MUL A=0x10001, B=0x10001 -> result 0x00020001 exactly 32 edges after accept; inReady=0 throughout.
- outReady held 0 for 5 cycles after an ORR result -> outputs stable, inReady=0; outReady=1 with a new inValid -> back-to-back accept.
- resetN=0 at the 10th MUL cycle -> outValid=0, all outputs 0, inReady=1 on the cycle after resetN rises.
- LSR A=0x80000000, B=31 -> result 1; aluOp=1111 -> result 0, nzcv=0100.
